// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 block decryptor, one inverse round per clock.
// The forward key schedule is replayed first (EXPAND) to reach the last round
// key, then the rounds are undone while the schedule is stepped backwards.
// Optional feature macro: PRESENT_KEY_CACHE_EN. When defined, the last round key
// of the most recently expanded cipher key is kept, so a repeat key skips EXPAND.
module present_decrypt #(
    parameter int unsigned ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [79:0] key,
    input  logic [63:0] ct,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] pt,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

    localparam logic [4:0] LAST = 5'(ROUNDS);

    state_t      state;
    state_t      state_nx;
    logic [63:0] d;
    logic [79:0] kreg;
    logic [4:0]  cnt;

    logic [63:0] d_step;
    logic [79:0] k_fwd;
    logic [79:0] k_inv;
    logic        accept;
    logic        cache_hit;
    logic [79:0] hit_k32;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
            4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
            4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
            4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
        endcase
    endfunction

    // Forward P moves bit i to 16*i mod 63, so output bit i is read back from there.
    function automatic logic [63:0] inv_p(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 63; i++) y[i] = x[(16 * i) % 63];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ i;
        return r;
    endfunction

    function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ i;
        r[79:76]   = inv_sbox(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    assign d_step = inv_s_layer(inv_p(d ^ kreg[79:16]));
    assign k_fwd  = key_fwd(kreg, cnt);
    assign k_inv  = key_inv(kreg, cnt);
    assign accept = (state == IDLE) && in_valid;

`ifdef PRESENT_KEY_CACHE_EN
    logic        cache_vld;
    logic [79:0] cache_key;
    logic [79:0] cache_k32;

    assign cache_hit = cache_vld && (key == cache_key);
    assign hit_k32   = cache_k32;

    // Cache: remember the key on a miss, capture its last round key when EXPAND ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld <= 1'b0;
            cache_key <= '0;
            cache_k32 <= '0;
        end else if (accept && !cache_hit) begin
            cache_vld <= 1'b0;
            cache_key <= key;
        end else if (state == EXPAND && cnt == LAST) begin
            cache_vld <= 1'b1;
            cache_k32 <= k_fwd;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_k32   = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = cache_hit ? DECRYPT : EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (cnt == LAST) state_nx = DECRYPT;
            end
            DECRYPT: begin
                busy = 1'b1;
                if (cnt == 5'd1) state_nx = DONE;
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, replay the schedule, then undo one round per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            kreg <= '0;
            cnt  <= '0;
            pt   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values of the others.
            case (state)
                IDLE: if (accept) begin
                    d <= ct;
                    if (cache_hit) begin
                        kreg <= hit_k32;
                        cnt  <= LAST;
                    end else begin
                        kreg <= key;
                        cnt  <= 5'd1;
                    end
                end
                EXPAND: begin
                    kreg <= k_fwd;
                    cnt  <= (cnt == LAST) ? LAST : cnt + 5'd1;
                end
                DECRYPT: begin
                    d    <= d_step;
                    kreg <= k_inv;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) pt <= d_step ^ k_inv[79:16];
                end
                default: ;
            endcase
        end
    end

endmodule
